// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state encoding, ALUOp codes and select encodings
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_JALS   = 4'd12, S_JR     = 4'd13, S_TRAP   = 4'd14, S_UNUSED = 4'd15
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_ADDI  = 3'b110;
  localparam logic [2:0] ALU_ANDI  = 3'b011;
  localparam logic [2:0] ALU_ORI   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b001;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic [2:0] itype_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_ANDI;
      OP_ORI:  return ALU_ORI;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADDI;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// rtl/mips_ctrl_if.sv - controller <-> datapath signal bundle
interface mips_ctrl_if #(parameter int ALUOP_W = 3);
  logic [5:0]         OP;
  logic [5:0]         Funct;
  logic               mem_ready;
  logic               IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic               BranchEQ, BranchNE, RegWrite, ALUSrcA;
  logic [1:0]         RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [ALUOP_W-1:0] ALUOp;
  logic               illegal_op;
  logic [3:0]         state;

  modport master (
    input  OP, Funct, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, PCWrite, BranchEQ, BranchNE,
           RegWrite, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp,
           illegal_op, state
  );

  modport slave (
    output OP, Funct, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, PCWrite, BranchEQ, BranchNE,
           RegWrite, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp,
           illegal_op, state
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - state/opcode to control-word decoder
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  op_i,
  input  logic        mem_ready_i,
  input  logic        kill_i,
  output ctrl_t       ctrl_o,
  output logic [3:0]  state_o
);

  ctrl_t ctrl_raw;

  always_comb begin
    ctrl_raw = '0;
    case (state_i)
      S_DECODE: begin
        ctrl_raw.alu_src_b = SRCB_IMM_SH;
        ctrl_raw.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_IMM;
        ctrl_raw.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_raw.iord     = 1'b1;
        ctrl_raw.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl_raw.reg_dst    = REGDST_RT;
        ctrl_raw.mem_to_reg = M2R_MDR;
        ctrl_raw.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_raw.iord      = 1'b1;
        ctrl_raw.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_B;
        ctrl_raw.alu_op    = ALU_RTYPE;
      end
      S_RWB: begin
        ctrl_raw.reg_dst    = REGDST_RD;
        ctrl_raw.mem_to_reg = M2R_ALUOUT;
        ctrl_raw.reg_write  = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_IMM;
        ctrl_raw.alu_op    = itype_aluop(op_i);
      end
      S_IWB: begin
        ctrl_raw.reg_dst    = REGDST_RT;
        ctrl_raw.mem_to_reg = M2R_ALUOUT;
        ctrl_raw.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = SRCB_B;
        ctrl_raw.alu_op    = ALU_SUB;
        ctrl_raw.pc_source = PCSRC_ALUOUT;
        ctrl_raw.branch_eq = (op_i == OP_BEQ);
        ctrl_raw.branch_ne = (op_i == OP_BNE);
      end
      S_JUMP: begin
        ctrl_raw.pc_source = PCSRC_JUMP;
        ctrl_raw.pc_write  = 1'b1;
      end
      // Links the PC already advanced to PC+4 during FETCH
      S_JALS: begin
        ctrl_raw.pc_source  = PCSRC_JUMP;
        ctrl_raw.pc_write   = 1'b1;
        ctrl_raw.reg_dst    = REGDST_RA;
        ctrl_raw.mem_to_reg = M2R_PC;
        ctrl_raw.reg_write  = 1'b1;
      end
      S_JR: begin
        ctrl_raw.pc_source = PCSRC_RS;
        ctrl_raw.pc_write  = 1'b1;
      end
      S_TRAP: ctrl_raw.illegal_op = 1'b1;
      default: begin
        ctrl_raw.mem_read  = 1'b1;
        ctrl_raw.alu_src_b = SRCB_FOUR;
        ctrl_raw.alu_op    = ALU_ADD;
        ctrl_raw.pc_source = PCSRC_ALU;
        ctrl_raw.ir_write  = mem_ready_i;
        ctrl_raw.pc_write  = mem_ready_i;
      end
    endcase
  end

  // Reset must silence every strobe in the same cycle, not at the next edge
  assign ctrl_o  = kill_i ? '0 : ctrl_raw;
  assign state_o = kill_i ? 4'd0 : state_i;

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM: state register and sequencing
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W         = 3,
  parameter int MEM_HANDSHAKE   = 1,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic          clk,
  input  logic          reset,
  mips_ctrl_if.master   bus
);

  state_e state_q, state_d;
  logic   mem_rdy;
  ctrl_t  ctrl;

  assign mem_rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.OP)
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_R:                             state_d = (bus.Funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          OP_JAL:                           state_d = S_JALS;
          default: state_d = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.OP == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXEC_R: state_d = S_RWB;
      S_EXEC_I: state_d = S_IWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .op_i        (bus.OP),
    .mem_ready_i (mem_rdy),
    .kill_i      (reset),
    .ctrl_o      (ctrl),
    .state_o     (bus.state)
  );

  assign bus.IorD       = ctrl.iord;
  assign bus.MemRead    = ctrl.mem_read;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.BranchEQ   = ctrl.branch_eq;
  assign bus.BranchNE   = ctrl.branch_ne;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.MemtoReg   = ctrl.mem_to_reg;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.PCSource   = ctrl.pc_source;
  assign bus.ALUOp      = ALUOP_W'(ctrl.alu_op);
  assign bus.illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  typedef logic [25:0] vec_t;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] J = 6'h02, JAL = 6'h03, ADDI = 6'h08, ANDI = 6'h0c, ORI = 6'h0d;
  localparam logic [5:0] LUI = 6'h0f, BAD = 6'h3f;

  // {IorD,MemRead,MemWrite,IRWrite,PCWrite,BranchEQ,BranchNE,RegWrite,ALUSrcA},
  // RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp(4, zero-extended), illegal_op, state
  localparam vec_t V_ZERO  = '0;
  localparam vec_t V_F1    = {9'b0_1_0_1_1_0_0_0_0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0010, 1'b0, 4'd0};
  localparam vec_t V_F0    = {9'b0_1_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0010, 1'b0, 4'd0};
  localparam vec_t V_DEC   = {9'b0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b11, 2'b00, 4'b0010, 1'b0, 4'd1};
  localparam vec_t V_MADR  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0010, 1'b0, 4'd2};
  localparam vec_t V_MRD   = {9'b1_1_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 4'd3};
  localparam vec_t V_MWB   = {9'b0_0_0_0_0_0_0_1_0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 1'b0, 4'd4};
  localparam vec_t V_MWR   = {9'b1_0_1_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 4'd5};
  localparam vec_t V_EXR   = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0111, 1'b0, 4'd6};
  localparam vec_t V_RWB   = {9'b0_0_0_0_0_0_0_1_0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 4'd7};
  localparam vec_t V_ADDI  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0110, 1'b0, 4'd8};
  localparam vec_t V_ORI   = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0101, 1'b0, 4'd8};
  localparam vec_t V_ANDI  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0011, 1'b0, 4'd8};
  localparam vec_t V_LUI   = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0001, 1'b0, 4'd8};
  localparam vec_t V_IWB   = {9'b0_0_0_0_0_0_0_1_0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 4'd9};
  localparam vec_t V_BNE   = {9'b0_0_0_0_0_0_1_0_1, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0100, 1'b0, 4'd10};
  localparam vec_t V_BEQ   = {9'b0_0_0_0_0_1_0_0_1, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0100, 1'b0, 4'd10};
  localparam vec_t V_JMP   = {9'b0_0_0_0_1_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b10, 4'b0000, 1'b0, 4'd11};
  localparam vec_t V_JAL   = {9'b0_0_0_0_1_0_0_1_0, 2'b10, 2'b10, 2'b00, 2'b10, 4'b0000, 1'b0, 4'd12};
  localparam vec_t V_JR    = {9'b0_0_0_0_1_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b11, 4'b0000, 1'b0, 4'd13};
  localparam vec_t V_TRAP  = {9'b0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, 4'd14};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_ctrl_if #(.ALUOP_W(3)) bus1 ();
  mips_ctrl_if #(.ALUOP_W(4)) bus2 ();

  multicycle_control #(.ALUOP_W(3), .MEM_HANDSHAKE(1), .TRAP_ON_ILLEGAL(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master)
  );
  multicycle_control #(.ALUOP_W(4), .MEM_HANDSHAKE(0), .TRAP_ON_ILLEGAL(0)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.master)
  );

  vec_t got1, got2;
  assign got1 = {bus1.IorD, bus1.MemRead, bus1.MemWrite, bus1.IRWrite, bus1.PCWrite,
                 bus1.BranchEQ, bus1.BranchNE, bus1.RegWrite, bus1.ALUSrcA,
                 bus1.RegDst, bus1.MemtoReg, bus1.ALUSrcB, bus1.PCSource,
                 {1'b0, bus1.ALUOp}, bus1.illegal_op, bus1.state};
  assign got2 = {bus2.IorD, bus2.MemRead, bus2.MemWrite, bus2.IRWrite, bus2.PCWrite,
                 bus2.BranchEQ, bus2.BranchNE, bus2.RegWrite, bus2.ALUSrcA,
                 bus2.RegDst, bus2.MemtoReg, bus2.ALUSrcB, bus2.PCSource,
                 bus2.ALUOp, bus2.illegal_op, bus2.state};

  vec_t q1[$], q2[$];
  int   t1[$], t2[$];
  int   n_pass = 0, n_total = 0, step_no = 0;
  vec_t e1, e2;
  int   s1, s2;

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      s1 = t1.pop_front();
      n_total++;
      if (got1 === e1) n_pass++;
      else $display("FAIL dut1 step %0d: got %h required %h", s1, got1, e1);
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      s2 = t2.pop_front();
      n_total++;
      if (got2 === e2) n_pass++;
      else $display("FAIL dut2 step %0d: got %h required %h", s2, got2, e2);
    end
  end

  task automatic step(input int sel, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic mr, input vec_t exp);
    reset = rst;
    if (sel == 1) begin
      bus1.OP = op; bus1.Funct = fn; bus1.mem_ready = mr;
      q1.push_back(exp); t1.push_back(step_no);
    end else begin
      bus2.OP = op; bus2.Funct = fn; bus2.mem_ready = mr;
      q2.push_back(exp); t2.push_back(step_no);
    end
    step_no++;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus1.OP = 6'h00; bus1.Funct = 6'h00; bus1.mem_ready = 1'b0;
    bus2.OP = 6'h00; bus2.Funct = 6'h00; bus2.mem_ready = 1'b0;
    @(posedge clk); #1;

    step(1, 1, LW, 0, 1, V_ZERO);
    step(1, 0, LW, 0, 1, V_F1); step(1, 0, LW, 0, 1, V_DEC); step(1, 0, LW, 0, 1, V_MADR);
    step(1, 0, LW, 0, 1, V_MRD); step(1, 0, LW, 0, 1, V_MWB);
    step(1, 0, LW, 0, 1, V_F1); step(1, 0, LW, 0, 1, V_DEC); step(1, 0, LW, 0, 1, V_MADR);
    step(1, 0, LW, 0, 0, V_MRD); step(1, 0, LW, 0, 0, V_MRD); step(1, 0, LW, 0, 1, V_MRD);
    step(1, 0, LW, 0, 1, V_MWB);
    step(1, 0, SW, 0, 0, V_F0); step(1, 0, SW, 0, 1, V_F1); step(1, 0, SW, 0, 1, V_DEC);
    step(1, 0, SW, 0, 1, V_MADR);
    for (int i = 0; i < 3; i++) step(1, 0, SW, 0, 0, V_MWR);
    step(1, 0, SW, 0, 1, V_MWR);
    step(1, 0, RT, 6'h20, 1, V_F1); step(1, 0, RT, 6'h20, 1, V_DEC);
    step(1, 0, RT, 6'h20, 1, V_EXR); step(1, 0, RT, 6'h20, 1, V_RWB);
    step(1, 0, RT, 6'h08, 1, V_F1); step(1, 0, RT, 6'h08, 1, V_DEC); step(1, 0, RT, 6'h08, 1, V_JR);
    step(1, 0, BNE, 0, 1, V_F1); step(1, 0, BNE, 0, 1, V_DEC); step(1, 0, BNE, 0, 1, V_BNE);
    step(1, 0, BEQ, 0, 1, V_F1); step(1, 0, BEQ, 0, 1, V_DEC); step(1, 0, BEQ, 0, 1, V_BEQ);
    step(1, 0, JAL, 0, 1, V_F1); step(1, 0, JAL, 0, 1, V_DEC); step(1, 0, JAL, 0, 1, V_JAL);
    step(1, 0, J, 0, 1, V_F1); step(1, 0, J, 0, 1, V_DEC); step(1, 0, J, 0, 1, V_JMP);
    step(1, 0, ADDI, 0, 1, V_F1); step(1, 0, ADDI, 0, 1, V_DEC);
    step(1, 0, ADDI, 0, 1, V_ADDI); step(1, 0, ADDI, 0, 1, V_IWB);
    step(1, 0, ORI, 0, 1, V_F1); step(1, 0, ORI, 0, 1, V_DEC);
    step(1, 0, ORI, 0, 1, V_ORI); step(1, 0, ORI, 0, 1, V_IWB);
    step(1, 0, SW, 0, 1, V_F1); step(1, 0, SW, 0, 1, V_DEC); step(1, 0, SW, 0, 1, V_MADR);
    step(1, 0, SW, 0, 0, V_MWR);
    step(1, 1, SW, 0, 0, V_ZERO); step(1, 1, SW, 0, 1, V_ZERO);
    step(1, 0, BAD, 0, 1, V_F1); step(1, 0, BAD, 0, 1, V_DEC);
    for (int i = 0; i < 100; i++) step(1, 0, BAD, 6'(i), i[0], V_TRAP);
    step(1, 1, RT, 0, 1, V_ZERO);
    step(1, 0, RT, 0, 1, V_F1);

    step(2, 1, BAD, 0, 0, V_ZERO);
    step(2, 0, BAD, 0, 0, V_F1); step(2, 0, BAD, 0, 0, V_DEC);
    step(2, 0, ANDI, 0, 0, V_F1); step(2, 0, ANDI, 0, 0, V_DEC);
    step(2, 0, ANDI, 0, 0, V_ANDI); step(2, 0, ANDI, 0, 0, V_IWB);
    step(2, 0, LUI, 0, 0, V_F1); step(2, 0, LUI, 0, 0, V_DEC);
    step(2, 0, LUI, 0, 0, V_LUI); step(2, 0, LUI, 0, 0, V_IWB);
    step(2, 0, LW, 0, 0, V_F1); step(2, 0, LW, 0, 0, V_DEC); step(2, 0, LW, 0, 0, V_MADR);
    step(2, 0, LW, 0, 0, V_MRD); step(2, 0, LW, 0, 0, V_MWB); step(2, 0, LW, 0, 0, V_F1);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS control unit: a Moore state machine that sequences each instruction over 3–5 cycles, driving a shared-memory, single-ALU datapath. It replaces the single-cycle opcode decoder. It adds:
- memory wait-state handshake
- JAL and JR support
- an illegal-opcode trap mode
- a parametrised ALUOp width

## Interface
Parameters:
- ALUOP_W, 3: ALUOp width, ≥3; codes below zero-extended.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready treated as constant 1.
- TRAP_ON_ILLEGAL, 1: 1 = unknown opcode enters TRAP; 0 = executes as NOP.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- OP  in  6  instruction opcode (from IR).
- Funct  in  6  instruction funct field (from IR).
- mem_ready  in  1  memory completed current access this cycle.
- IorD, MemRead, MemWrite, IRWrite, PCWrite, BranchEQ, BranchNE, RegWrite, ALUSrcA  out  1 each.
- RegDst  out  2  00 rt, 01 rd, 10 $ra.
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- ALUSrcB  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (A register).
- ALUOp  out  ALUOP_W  010 add, 100 sub/branch, 111 R-type funct, 110 addi, 011 andi, 101 ori, 001 lui.
- illegal_op  out  1  sticky trap flag.
- state  out  4  current state, for debug.

## Operation
Opcodes:
- R 0x00; JR is R with Funct 0x08.
- ADDI 0x08, ANDI 0x0c, ORI 0x0d, LUI 0x0f.
- LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.

States (encoding = index). Every output not listed is 0.
- 0 FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00.
  - IRWrite=PCWrite=mem_ready (the only Mealy outputs).
  - Stay until mem_ready, then DECODE.
- 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=010. Next state:
  - LW/SW → MEMADR
  - R: Funct 0x08 → JR, else EXEC_R
  - ADDI/ANDI/ORI/LUI → EXEC_I
  - BEQ/BNE → BRANCH
  - J → JUMP
  - JAL → JALS
  - otherwise → TRAP, or FETCH when TRAP_ON_ILLEGAL=0.
- 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=010. LW → MEMRD, SW → MEMWR.
- 3 MEMRD: IorD=1, MemRead=1. Wait for mem_ready, then MEMWB.
- 4 MEMWB: RegDst=00, MemtoReg=01, RegWrite=1. Next FETCH.
- 5 MEMWR: IorD=1, MemWrite=1. Wait for mem_ready, then FETCH.
- 6 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next RWB.
- 7 RWB: RegDst=01, MemtoReg=00, RegWrite=1. Next FETCH.
- 8 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode. Next IWB.
- 9 IWB: RegDst=00, MemtoReg=00, RegWrite=1. Next FETCH.
- 10 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSource=01.
  - BranchEQ=1 for BEQ, BranchNE=1 for BNE.
  - Next FETCH.
- 11 JUMP: PCSource=10, PCWrite=1. Next FETCH.
- 12 JALS: PCSource=10, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1. Next FETCH.
  - The PC written to $ra is the already-incremented PC+4.
- 13 JR: PCSource=11, PCWrite=1. Next FETCH.
- 14 TRAP: illegal_op=1. Absorbing until reset.
- 15: unreachable; decodes to FETCH outputs and next-state FETCH.

Rules:
- OP and Funct are sampled only in DECODE; the datapath holds IR stable.
- While reset is high, state=FETCH and every output is forced to 0, including state (read as 0) and illegal_op.
- Reset mid-instruction aborts immediately; no write strobe may be asserted while reset is high.

## Timing
- State register updates on the rising clk edge. Outputs are combinational from state (plus mem_ready in FETCH only).
- Cycle counts with zero-wait memory, FETCH through last state:
  - LW 5
  - SW, R, I-type 4
  - BEQ/BNE, J, JAL, JR 3
- Each memory wait cycle adds 1 cycle (FETCH, MEMRD, MEMWR).
- mem_ready may arrive on the first cycle of a memory state; it is ignored in all other states.
- First FETCH occurs in the cycle after reset deasserts. PCWrite may pulse in that cycle if mem_ready=1.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode and Funct constants
  - the 4-bit state enum/localparams
  - ALUOp codes
  - RegDst, MemtoReg, ALUSrcB and PCSource select encodings
- Sub-module mips_ctrl_outdec: combinational state/opcode → control-word decoder.
- The top module keeps only the state register and next-state logic.

## Test plan
- Reset asserted mid-MEMWR with MemWrite=1 → all outputs 0 the same cycle; after release, state=0 and MemRead=1.
- LW, mem_ready always 1 → states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=01 only in state 4.
- SW with MEM_HANDSHAKE=1, mem_ready low 3 cycles in MEMWR → MemWrite held 4 cycles; single FETCH afterwards.
- R ADD (OP 0x00, Funct 0x20) → ALUOp=111 in state 6, RegDst=01 write in state 7. JR (Funct 0x08) → state 13, PCSource=11, PCWrite=1.
- BNE → BranchNE=1, BranchEQ=0, ALUOp=100 in state 10. JAL → state 12 with RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1.
- OP 0x3f:
  - TRAP_ON_ILLEGAL=1 → state 14, illegal_op=1 held across 100 cycles, cleared only by reset.
  - TRAP_ON_ILLEGAL=0 → DECODE then FETCH, illegal_op=0.
